// File: rtl/reg_file_scoreboarded_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded register file slice.
//   DEF_DATA_W   : default register width
//   DEF_NUM_REGS : default register count (power of two)
//   DEF_ADDR_W   : index width matching DEF_NUM_REGS
//   DEF_CNT_W    : width of the busy counter (can hold NUM_REGS itself)
//   regIdx_t     : register index type for the default configuration
//   cntOne       : helper that widens a single-bit event to counter width
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
   localparam int DEF_CNT_W    = DEF_ADDR_W + 1;

   typedef logic [DEF_ADDR_W-1:0] regIdx_t;

   // Widens a one-bit increment/decrement event to the default counter width.
   function automatic logic [DEF_CNT_W-1:0] cntOne(input logic ev);
      cntOne = {{(DEF_CNT_W-1){1'b0}}, ev};
   endfunction

endpackage

// File: rtl/reg_file_scoreboarded_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy tracking for the register file. The issue stage reserves
// a destination; writeback releases it. Exposes the read-port busy flags, the
// issue permission and a registered count of busy registers.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   rd_addr_a/b          : read port indices whose busy state is reported
//   rd_busy_a/b          : register has a pending write (same-cycle release seen)
//   wr_en, wr_addr       : writeback strobe and index (releases busy)
//   iss_en, iss_addr     : reservation request and destination index
//   iss_ok               : destination free or being released this cycle
//   busy_cnt             : number of busy registers, registered
// ---------------------------------------------------------------------------
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              rd_busy_a,
   output logic              rd_busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              iss_ok,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int CNT_W = ADDR_W + 1;

   logic [NUM_REGS-1:0] r_busyVec;
   logic [CNT_W-1:0]    r_busyCnt;
   logic [NUM_REGS-1:0] w_nextBusy;
   logic                w_issZero;
   logic                w_setAcc;
   logic                w_inc;
   logic                w_dec;
   logic [CNT_W-1:0]    w_incExt;
   logic [CNT_W-1:0]    w_decExt;

   // A writeback to the same index releases it in this cycle, so a new producer
   // may reserve it immediately; otherwise the destination must be idle.
   assign iss_ok = !r_busyVec[iss_addr] || (wr_en && (wr_addr == iss_addr));

   // The hardwired zero register accepts reservations but never becomes busy,
   // since nothing will ever write it back.
   assign w_issZero = (ZERO_REG != 0) && (iss_addr == '0);
   assign w_setAcc  = iss_en && iss_ok && !w_issZero;

   // Read-side busy flags see the release of a writeback happening this cycle,
   // matching the data bypass that delivers the value in the same cycle.
   assign rd_busy_a = r_busyVec[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
   assign rd_busy_b = r_busyVec[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));

   // Clear first, then set, so a simultaneous release and reservation of the
   // same index leaves it busy for the new producer.
   always_comb begin
      w_nextBusy = r_busyVec;
      if (wr_en) begin
         w_nextBusy[wr_addr] = 1'b0;
      end
      if (w_setAcc) begin
         w_nextBusy[iss_addr] = 1'b1;
      end
   end

   // Count only real transitions: a set of an idle bit adds one, a release of a
   // busy bit subtracts one unless the same bit is re-reserved in that cycle.
   assign w_inc    = w_setAcc && !r_busyVec[iss_addr];
   assign w_dec    = wr_en && r_busyVec[wr_addr] && !(w_setAcc && (iss_addr == wr_addr));
   assign w_incExt = {{(CNT_W-1){1'b0}}, w_inc};
   assign w_decExt = {{(CNT_W-1){1'b0}}, w_dec};

   // Busy vector and its population count, both cleared by reset so any
   // in-flight reservation is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busyVec <= '0;
         r_busyCnt <= '0;
      end else begin
         r_busyVec <= w_nextBusy;
         r_busyCnt <= r_busyCnt + w_incExt - w_decExt;
      end
   end

   assign busy_cnt = r_busyCnt;

endmodule

// File: rtl/reg_file_scoreboarded.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboarded
// Register file for the integer or FP datapath with two combinational read
// ports, one synchronous write port, write-through bypass and a per-register
// busy scoreboard used by the hazard logic.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   rd_addr_a/b          : read indices
//   rd_data_a/b          : read data, bypassed from the write port
//   rd_busy_a/b          : read register has a pending write
//   wr_en/wr_addr/wr_data: writeback port (also releases busy)
//   iss_en/iss_addr      : destination reservation from issue
//   iss_ok               : reservation may be accepted this cycle
//   busy_cnt             : number of busy registers
// ---------------------------------------------------------------------------
module reg_file_scoreboarded
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_a,
   output logic              rd_busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              iss_ok,
   output logic [ADDR_W:0]   busy_cnt
);

   logic [DATA_W-1:0] r_regArray [NUM_REGS];
   logic              w_wrWritable;
   logic              w_zeroA;
   logic              w_zeroB;

   // Writes to the hardwired zero register are dropped, both for storage and
   // for the bypass path.
   assign w_wrWritable = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   assign w_zeroA = (ZERO_REG != 0) && (rd_addr_a == '0);
   assign w_zeroB = (ZERO_REG != 0) && (rd_addr_b == '0);

   // Data array: reset clears every entry so a write in flight at reset leaves
   // no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regArray[i] <= '0;
         end
      end else if (w_wrWritable) begin
         r_regArray[wr_addr] <= wr_data;
      end
   end

   // Read muxes: zero register first, then the write-through bypass so decode
   // sees the value being written this cycle, then the stored value.
   always_comb begin
      rd_data_a = r_regArray[rd_addr_a];
      if (w_zeroA) begin
         rd_data_a = '0;
      end else if (w_wrWritable && (wr_addr == rd_addr_a)) begin
         rd_data_a = wr_data;
      end
   end

   always_comb begin
      rd_data_b = r_regArray[rd_addr_b];
      if (w_zeroB) begin
         rd_data_b = '0;
      end else if (w_wrWritable && (wr_addr == rd_addr_b)) begin
         rd_data_b = wr_data;
      end
   end

   // Busy tracking lives in its own block; the data path above only needs
   // the shared write strobe and index.
   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_busy_a (rd_busy_a),
      .rd_busy_b (rd_busy_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .iss_ok    (iss_ok),
      .busy_cnt  (busy_cnt)
   );

endmodule

// File: tb/tb_reg_file_scoreboarded.sv
// ---------------------------------------------------------------------------
// tb_reg_file_scoreboarded
// Directed bench for the scoreboarded register file. Two instances share the
// same stimulus: one with a hardwired zero register (integer bank) and one
// where register 0 is ordinary (FP bank).
// ---------------------------------------------------------------------------
module tb_reg_file_scoreboarded;
   import regfile_pkg::*;

   logic        clk;
   logic        rst;
   logic [4:0]  rdAddrA;
   logic [4:0]  rdAddrB;
   logic        wrEn;
   logic [4:0]  wrAddr;
   logic [31:0] wrData;
   logic        issEn;
   logic [4:0]  issAddr;

   logic [31:0] zRdDataA, zRdDataB, fRdDataA, fRdDataB;
   logic        zRdBusyA, zRdBusyB, fRdBusyA, fRdBusyB;
   logic        zIssOk, fIssOk;
   logic [5:0]  zBusyCnt, fBusyCnt;

   int total;
   int bad;

   reg_file_scoreboarded #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1)) dutZ (
      .clk(clk), .rst(rst),
      .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
      .rd_data_a(zRdDataA), .rd_data_b(zRdDataB),
      .rd_busy_a(zRdBusyA), .rd_busy_b(zRdBusyB),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .iss_en(issEn), .iss_addr(issAddr),
      .iss_ok(zIssOk), .busy_cnt(zBusyCnt)
   );

   reg_file_scoreboarded #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(0)) dutF (
      .clk(clk), .rst(rst),
      .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
      .rd_data_a(fRdDataA), .rd_data_b(fRdDataB),
      .rd_busy_a(fRdBusyA), .rd_busy_b(fRdBusyB),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .iss_en(issEn), .iss_addr(issAddr),
      .iss_ok(fIssOk), .busy_cnt(fBusyCnt)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives all request inputs at once and lets combinational outputs settle.
   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra, input logic [4:0] rb);
      wrEn    = we;
      wrAddr  = wa;
      wrData  = wd;
      issEn   = ie;
      issAddr = ia;
      rdAddrA = ra;
      rdAddrB = rb;
      #1;
   endtask

   // Advance one clock, landing 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state across every address on both ports
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'(a), 5'(a), 5'(31 - a));
         checkOutput("rstDataZ", zRdDataA | zRdDataB, 32'h0);
         checkOutput("rstDataF", fRdDataA | fRdDataB, 32'h0);
         checkOutput("rstBusy", {28'h0, zRdBusyA, zRdBusyB, fRdBusyA, fRdBusyB}, 32'h0);
         checkOutput("rstIssOk", {30'h0, zIssOk, fIssOk}, 32'h3);
      end
      checkOutput("rstCntZ", {26'h0, zBusyCnt}, 32'h0);
      checkOutput("rstCntF", {26'h0, fBusyCnt}, 32'h0);

      // Write-through bypass on r5, then the stored value
      applyStimulus(1'b1, 5'd5, 32'h3F800000, 1'b0, 5'd0, 5'd5, 5'd6);
      checkOutput("bypassA", zRdDataA, 32'h3F800000);
      checkOutput("bypassOther", zRdDataB, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd5);
      checkOutput("storedB", zRdDataB, 32'h3F800000);
      checkOutput("storedBF", fRdDataB, 32'h3F800000);

      // Register 0: hardwired zero vs ordinary
      applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("r0BypZ", zRdDataA, 32'h0);
      checkOutput("r0BypF", fRdDataA, 32'hDEADBEEF);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("r0StoreZ", zRdDataA, 32'h0);
      checkOutput("r0StoreF", fRdDataA, 32'hDEADBEEF);

      // Reserve r7, retry is refused, writeback releases
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5);
      checkOutput("iss7Ok", {31'h0, zIssOk}, 32'h1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd5);
      checkOutput("r7Busy", {31'h0, zRdBusyA}, 32'h1);
      checkOutput("r7Cnt", {26'h0, zBusyCnt}, 32'h1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5);
      checkOutput("iss7Again", {31'h0, zIssOk}, 32'h0);
      tick();
      checkOutput("r7CntHold", {26'h0, zBusyCnt}, 32'h1);
      applyStimulus(1'b1, 5'd7, 32'h00000011, 1'b0, 5'd7, 5'd7, 5'd5);
      checkOutput("r7RelSame", {31'h0, zRdBusyA}, 32'h0);
      checkOutput("r7IssOkRel", {31'h0, zIssOk}, 32'h1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5);
      checkOutput("r7CntZero", {26'h0, zBusyCnt}, 32'h0);
      checkOutput("r7BusyClr", {31'h0, zRdBusyA}, 32'h0);
      checkOutput("r7Data", zRdDataA, 32'h00000011);

      // Reserving r0: ignored on the zero bank, real on the FP bank
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("iss0OkZ", {31'h0, zIssOk}, 32'h1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("r0CntZ", {26'h0, zBusyCnt}, 32'h0);
      checkOutput("r0CntF", {26'h0, fBusyCnt}, 32'h1);
      checkOutput("r0BusyZ", {31'h0, zRdBusyA}, 32'h0);
      checkOutput("r0BusyF", {31'h0, fRdBusyA}, 32'h1);
      applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("r0RelCntF", {26'h0, fBusyCnt}, 32'h0);

      // r9: release and re-reserve in the same cycle keeps it busy
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd9, 5'd0);
      checkOutput("r9IssOk", {31'h0, zIssOk}, 32'h1);
      checkOutput("r9RelVis", {31'h0, zRdBusyA}, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
      checkOutput("r9StillBusy", {31'h0, zRdBusyA}, 32'h1);
      checkOutput("r9Cnt", {26'h0, zBusyCnt}, 32'h1);
      checkOutput("r9Data", zRdDataA, 32'h12345678);

      // Write to an idle register leaves the count alone
      applyStimulus(1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd10, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
      checkOutput("r10Cnt", {26'h0, zBusyCnt}, 32'h1);
      checkOutput("r10Busy", {31'h0, zRdBusyA}, 32'h0);

      // Reserve r11 while releasing r9: net zero, then release r11
      applyStimulus(1'b1, 5'd9, 32'h0, 1'b1, 5'd11, 5'd9, 5'd11);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd11);
      checkOutput("swapCnt", {26'h0, zBusyCnt}, 32'h1);
      checkOutput("swapBusy", {30'h0, zRdBusyA, zRdBusyB}, 32'h1);
      applyStimulus(1'b1, 5'd11, 32'h0, 1'b0, 5'd0, 5'd9, 5'd11);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd11);
      checkOutput("drainCnt", {26'h0, zBusyCnt}, 32'h0);

      // Three reservations, then reset mid-cycle
      for (int r = 1; r <= 3; r++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd1, 5'd5);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 5'd1, 5'd5);
      checkOutput("threeCntZ", {26'h0, zBusyCnt}, 32'h3);
      checkOutput("threeCntF", {26'h0, fBusyCnt}, 32'h3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstCnt", {26'h0, zBusyCnt}, 32'h0);
      checkOutput("midRstBusy", {31'h0, zRdBusyA}, 32'h0);
      checkOutput("midRstIssOk", {31'h0, zIssOk}, 32'h1);
      checkOutput("midRstData", zRdDataB, 32'h0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 5'd7);
      checkOutput("postRstR0F", fRdDataA, 32'h0);
      checkOutput("postRstR7", zRdDataB, 32'h0);
      checkOutput("postRstCntF", {26'h0, fBusyCnt}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
